phase_sync: RTL
===============

# phase_sync

Synchronous consumer of the dual-rail phase tokens produced by the self-timed phase generator ring. Samples the asynchronous PH0/PH1/PH2 channels into the `clk` domain and detects a stable token. Decodes it into one-hot phase strobes for the clocked datapath and returns the four-phase `ack` that gates the ring's advance. It also flags protocol violations: illegal codewords, out-of-order phases and stalled return-to-null.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input-bit synchroniser (≥2).
- `SETTLE_CYCLES`, default 2: consecutive identical post-sync samples required before a token is accepted (≥1).
- `TIMEOUT`, default 255: maximum cycles `ack` may stay high waiting for null before `err_timeout` (≥1).
- `CNT_W`, default 16: width of the phase counter.

- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `ph0`, input, 2: phase 0 dual-rail channel, asynchronous. [1]=true rail, [0]=false rail.
- `ph1`, input, 2: phase 1 dual-rail channel, asynchronous.
- `ph2`, input, 2: phase 2 dual-rail channel, asynchronous.
- `ack`, output, 1: four-phase acknowledge to the ring, registered.
- `ph_onehot`, output, 3: currently held phase. Bit n = PHn.
- `ph_strobe`, output, 1: one-cycle pulse when a new phase is accepted.
- `phase_cnt`, output, CNT_W: number of accepted phases, wraps.
- `err_illegal`, output, 1: sticky. A channel showed 2'b11, or more than one channel was true.
- `err_order`, output, 1: sticky. An accepted phase was not the expected successor.
- `err_timeout`, output, 1: sticky. Null was not seen within TIMEOUT cycles of ack rising.

## Operation
- Channel decode, after sync: `2'b00` = null, `2'b10` = true, `2'b01` = false, `2'b11` = illegal.
- A data word means no channel is null, exactly one channel is true, and none is illegal.
- FSM states:
  - WAIT_DATA, reset state. `ack`=0. Stays here until the sampled word is a data word, then goes to SETTLE and loads the settle counter.
  - SETTLE, `ack`=0. A sample equal to the captured word decrements the counter. A differing sample returns to WAIT_DATA. When SETTLE_CYCLES matching samples are reached: latch `ph_onehot`, pulse `ph_strobe`, increment `phase_cnt`, run the order check, set `ack`=1, go to WAIT_NULL.
  - WAIT_NULL, `ack`=1. The timeout counter increments every cycle. When the accepted channel samples null: `ack`=0, clear the timeout counter, go to WAIT_DATA. When the counter reaches TIMEOUT: set `err_timeout`, keep `ack`=1 and stay in the state; the FSM still exits normally once null arrives.
- Order rule: the expected first phase after reset is PH0, then PH0→PH1→PH2→PH0. A mismatch sets `err_order`, the phase is still accepted, and the expectation resyncs to the successor of the accepted phase.
- Illegal handling: any sampled 2'b11, or two or more true channels, in any state sets `err_illegal`. The FSM ignores the word, so it is never accepted as data.
- `ph_onehot` holds its value until the next acceptance.
- `phase_cnt` wraps from all-ones to 0.
- Reset values: `ack`=0, `ph_onehot`=3'b000, `ph_strobe`=0, `phase_cnt`=0, all error flags 0, synchronisers cleared, expectation = PH0.
- Reset asserted mid-handshake, including with `ack`=1: all outputs return to reset values on the next edge, independent of the input state.

## Timing
- Input to first registered sample: SYNC_STAGES cycles.
- Stable token to `ph_strobe`/`ack` rise: SYNC_STAGES + SETTLE_CYCLES + 1 cycles, with defaults 5.
- Null on the active channel to `ack` fall: SYNC_STAGES + 1 cycles.
- `ph_strobe` is high for exactly one cycle per accepted phase.
- `ack` never toggles more than once per cycle and only changes on a state transition.
- Simultaneous null arrival and timeout expiry: null wins. `ack` falls and `err_timeout` is not set.

## Structure
- Shared package `phase_pkg`:
  - FSM state enum.
  - Dual-rail codeword constants: NULL, TRUE, FALSE, ILLEGAL.
  - Phase index type and `next_phase()` function.
- Sub-module `dr_sync`: SYNC_STAGES-deep synchroniser for one 2-bit dual-rail channel, instantiated three times.
- FSM, counters and error logic live in `phase_sync`.

## Test plan
- Reset then drive ph0=10, ph1=01, ph2=01 steady → `ph_strobe` pulse at cycle 5, `ph_onehot`=001, `ack`=1, `phase_cnt`=1. Then set ph0=00 → `ack`=0 three cycles later.
- Full rotation PH0→PH1→PH2→PH0 with correct null returns → four strobes, `phase_cnt`=4, all error flags 0.
- Glitch: a true token on ph1 for one post-sync cycle, then reverting → no strobe, FSM back in WAIT_DATA, `ack` stays 0.
- Drive ph2=11 for one cycle → `err_illegal`=1 and sticky, no strobe. Also ph0=10 with ph1=10 → `err_illegal`=1.
- After reset, first token on PH1 → accepted with `ph_onehot`=010 and `err_order`=1. Next PH2 token → no new order error.
- Hold the accepted channel true for 300 cycles → `err_timeout`=1 at TIMEOUT with `ack` still 1. Release to null → `ack`=0. Then assert `rst` while `ack`=1 → all outputs 0 next cycle.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared types and codeword constants for the phase-token synchroniser.
package phase_pkg;

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    SETTLE    = 2'd1,
    WAIT_NULL = 2'd2
  } state_t;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_TRUE    = 2'b10;
  localparam logic [1:0] DR_FALSE   = 2'b01;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef logic [1:0] phase_idx_t;

  // Ring order is PH0 -> PH1 -> PH2 -> PH0.
  function automatic phase_idx_t next_phase(input phase_idx_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/phase_sync_dr_sync.sv
// Multi-stage synchroniser for one asynchronous 2-bit dual-rail channel.
module dr_sync
  import phase_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  logic [1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= DR_NULL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/phase_sync.sv
// Clocked consumer of the self-timed phase ring: synchronises PH0..PH2,
// accepts stable tokens, returns the four-phase ack and flags protocol errors.
module phase_sync
  import phase_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ph0,
  input  logic [1:0]       ph1,
  input  logic [1:0]       ph2,
  output logic             ack,
  output logic [2:0]       ph_onehot,
  output logic             ph_strobe,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             err_illegal,
  output logic             err_order,
  output logic             err_timeout
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_PRE      = TO_W'(TIMEOUT - 1);

  logic [1:0] ch [3];

  dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (.clk(clk), .rst(rst), .din(ph0), .dout(ch[0]));
  dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (.clk(clk), .rst(rst), .din(ph1), .dout(ch[1]));
  dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (.clk(clk), .rst(rst), .din(ph2), .dout(ch[2]));

  logic [5:0]       word;
  logic [2:0]       is_true, is_null, is_bad;
  logic             multi_true, word_illegal, word_data, acc_null;
  phase_idx_t       acc_idx;

  assign word = {ch[2], ch[1], ch[0]};

  always_comb begin
    is_true = '0;
    is_null = '0;
    is_bad  = '0;
    for (int n = 0; n < 3; n++) begin
      is_true[n] = (ch[n] == DR_TRUE);
      is_null[n] = (ch[n] == DR_NULL);
      is_bad[n]  = (ch[n] == DR_ILLEGAL);
    end
  end

  assign multi_true   = (is_true[0] & is_true[1]) | (is_true[0] & is_true[2]) | (is_true[1] & is_true[2]);
  assign word_illegal = (|is_bad) | multi_true;
  assign word_data    = ~(|is_null) & ~word_illegal & (|is_true);
  // Only the channel that carried the accepted token releases the handshake.
  assign acc_null     = |(is_null & ph_onehot);

  always_comb begin
    acc_idx = 2'd0;
    if (is_true[1])      acc_idx = 2'd1;
    else if (is_true[2]) acc_idx = 2'd2;
  end

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [5:0]       cap_word;
  logic             capture, accept, ack_d, timeout_hit;
  phase_idx_t       expect_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_DATA;
      settle_q <= '0;
      tcnt_q   <= '0;
      cap_word <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tcnt_q   <= tcnt_d;
      if (capture) cap_word <= word;
    end
  end

  // Null has priority over timeout expiry in WAIT_NULL.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tcnt_d      = tcnt_q;
    ack_d       = ack;
    capture     = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (word_data) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
          capture  = 1'b1;
        end
      end
      SETTLE: begin
        if (word != cap_word) begin
          state_d = WAIT_DATA;
        end else if (settle_q == SET_W'(1)) begin
          accept  = 1'b1;
          ack_d   = 1'b1;
          tcnt_d  = '0;
          state_d = WAIT_NULL;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      WAIT_NULL: begin
        if (acc_null) begin
          ack_d   = 1'b0;
          tcnt_d  = '0;
          state_d = WAIT_DATA;
        end else if (tcnt_q != TO_MAX) begin
          tcnt_d = tcnt_q + TO_W'(1);
          if (tcnt_q == TO_PRE) timeout_hit = 1'b1;
        end
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack         <= 1'b0;
      ph_onehot   <= '0;
      ph_strobe   <= 1'b0;
      phase_cnt   <= '0;
      expect_q    <= 2'd0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ack       <= ack_d;
      ph_strobe <= accept;
      if (accept) begin
        ph_onehot <= is_true;
        phase_cnt <= phase_cnt + CNT_W'(1);
        if (acc_idx != expect_q) err_order <= 1'b1;
        expect_q  <= next_phase(acc_idx);
      end
      if (word_illegal) err_illegal <= 1'b1;
      if (timeout_hit)  err_timeout <= 1'b1;
    end
  end

endmodule
